uart_rx: RTL and testbench

Serial receiver that consumes the `tx` line produced by the transmit stage. It recovers 8N1 frames from an oversampling tick supplied by `Baud_tick_gen`, configured at BAUD × OVERSAMPLE. It presents each received byte with a one-clock `rx_done` strobe and flags frames whose stop bit is low. It is the RX half of the UART loopback path.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default frame constants
package uart_pkg;

    // Frame-level states, shared by the transmit and receive stages.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_BITS  = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer with selectable reset value
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full clock to settle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 serial receiver with framing-error flag
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state, state_next;
    logic [TW-1:0]        tick_cnt, tick_next;
    logic [BW-1:0]        bit_cnt, bit_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 done_next, err_next;

    // Idle-high line, so the synchronizer resets to 1 to avoid a false start bit.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign rx_busy = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, counter and strobe decode; everything holds between sample ticks.
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        done_next  = 1'b0;
        err_next   = 1'b0;
        if (sample_tick) begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_next = ST_START;
                        tick_next  = '0;
                    end
                end
                ST_START: begin
                    if (tick_cnt == HALF_LAST) begin
                        tick_next = '0;
                        if (!rx_s) begin
                            state_next = ST_DATA;
                            bit_next   = '0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        tick_next = tick_cnt + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_next  = '0;
                        shift_next = {rx_s, shift[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            state_next = ST_STOP;
                        end else begin
                            bit_next = bit_cnt + BW'(1);
                        end
                    end else begin
                        tick_next = tick_cnt + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_next  = '0;
                        state_next = ST_IDLE;
                        if (rx_s) begin
                            done_next = 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end else begin
                        tick_next = tick_cnt + TW'(1);
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Datapath registers and one-clock result strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            tick_cnt  <= tick_next;
            bit_cnt   <= bit_next;
            shift     <= shift_next;
            rx_done   <= done_next;
            frame_err <= err_next;
            if (done_next) begin
                rx_data <= shift;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 16x oversampling
module tb_uart_rx;

    localparam int OS = 16;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         start;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sample_tick = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_done = 0;
    int         n_err = 0;
    logic       prev_pulse = 1'b0;
    logic [7:0] model_data = 8'h00;
    exp_t       sb[$];
    int         done_hist[$];

    uart_rx #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .frame_err   (frame_err),
        .rx_busy     (rx_busy)
    );

    always #2 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every result strobe pops one expected frame.
    always @(negedge clk) begin
        if (rst && (rx_done || frame_err)) begin
            check_eq("pulse_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
            check_eq("pulse_width", {31'd0, prev_pulse}, 32'd0);
            if (sb.size() == 0) begin
                check_eq("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                int   lat;
                e = sb.pop_front();
                lat = cyc - e.start;
                check_eq("pulse_kind", {31'd0, frame_err}, {31'd0, e.err});
                check_eq("latency_155pm1", {31'd0, (lat >= 154 && lat <= 156)}, 32'd1);
                if (!e.err) begin
                    check_eq("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                    model_data <= e.data;
                    done_hist.push_back(cyc);
                end else begin
                    check_eq("rx_data_hold", {24'd0, rx_data}, {24'd0, model_data});
                end
            end
        end
        if (rst && rx_done) n_done <= n_done + 1;
        if (rst && frame_err) n_err <= n_err + 1;
        prev_pulse <= rx_done | frame_err;
    end

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_t e;
        e.err   = ~stop;
        e.data  = d;
        e.start = cyc;
        sb.push_back(e);
        drive(1'b0, OS);
        for (int i = 0; i < 8; i++) drive(d[i], OS);
        drive(stop, OS);
        rx = 1'b1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_eq("drain_timeout", sb.size(), 32'd0);
    endtask

    initial begin
        int busy_cnt;
        logic [7:0] partial;

        repeat (3) @(negedge clk);
        check_eq("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check_eq("reset_rx_done", {31'd0, rx_done}, 32'd0);
        check_eq("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check_eq("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(8'h55, 1'b1);
        wait_drain();
        check_eq("busy_after_55", {31'd0, rx_busy}, 32'd0);

        send_frame(8'hA3, 1'b1);
        wait_drain();
        repeat (10) @(negedge clk);

        busy_cnt = 0;
        rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            busy_cnt += int'(rx_busy);
        end
        rx = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            busy_cnt += int'(rx_busy);
        end
        check_eq("glitch_busy_le10", {31'd0, (busy_cnt > 0 && busy_cnt <= 10)}, 32'd1);
        check_eq("glitch_idle", {31'd0, rx_busy}, 32'd0);

        send_frame(8'h0F, 1'b0);
        wait_drain();
        repeat (40) @(negedge clk);
        check_eq("err_rx_data_kept", {24'd0, rx_data}, 32'h0000_00A3);
        check_eq("err_idle", {31'd0, rx_busy}, 32'd0);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain();
        if (done_hist.size() >= 2)
            check_eq("b2b_gap", done_hist[done_hist.size()-1] - done_hist[done_hist.size()-2], 32'd160);
        else
            check_eq("b2b_count", done_hist.size(), 32'd5);
        repeat (5) @(negedge clk);

        partial = 8'h5A;
        drive(1'b0, OS);
        for (int i = 0; i < 4; i++) drive(partial[i], OS);
        drive(partial[4], 8);
        rst = 1'b0;
        #1;
        check_eq("midreset_rx_data", {24'd0, rx_data}, 32'd0);
        check_eq("midreset_rx_done", {31'd0, rx_done}, 32'd0);
        check_eq("midreset_frame_err", {31'd0, frame_err}, 32'd0);
        check_eq("midreset_rx_busy", {31'd0, rx_busy}, 32'd0);
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("post_reset_idle", {31'd0, rx_busy}, 32'd0);

        send_frame(8'h3C, 1'b1);
        wait_drain();
        repeat (20) @(negedge clk);

        check_eq("total_rx_done", n_done, 32'd5);
        check_eq("total_frame_err", n_err, 32'd1);
        check_eq("final_rx_data", {24'd0, rx_data}, 32'h0000_003C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
